// File: rtl/rdma_req_sched_pkg.sv
// Shared types and defaults for the RDMA request scheduler.
package rdma_req_sched_pkg;

  // Default region count and outstanding-write window of the shell.
  localparam int LYNX_N_REGIONS        = 1;
  localparam int RDMA_N_WR_OUTSTANDING = 8;

  // One RDMA request descriptor as issued by a vFPGA region.
  typedef struct packed {
    logic [4:0]  opcode;
    logic [3:0]  vfid;
    logic [5:0]  pid;
    logic [3:0]  dest;
    logic        last;
    logic [27:0] len;
    logic [47:0] vaddr;
  } dreq_t;

  // Scheduler FSM: wait for an eligible requester, then hold its word until taken.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sched_state_t;

  // Index width for n entries, never zero so single-region builds keep legal vectors.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rdma_req_sched_rr_prio_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_prio_pick
  import rdma_req_sched_pkg::*;
#(
  parameter int N  = 1,
  parameter int IW = idx_bits(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Scan offsets 0..N-1 from the pointer; the first hit wins.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rdma_req_sched.sv
// Round-robin scheduler sharing one RDMA request path between vFPGA regions,
// with a per-region outstanding-request credit counter.
module rdma_req_sched
  import rdma_req_sched_pkg::*;
#(
  parameter  int N_REGIONS      = LYNX_N_REGIONS,
  parameter  int REQ_BITS       = $bits(dreq_t),
  parameter  int N_OST          = RDMA_N_WR_OUTSTANDING,
  localparam int N_REGIONS_BITS = idx_bits(N_REGIONS),
  localparam int CW             = $clog2(N_OST) + 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_REGIONS-1:0]          s_req_valid,
  output logic [N_REGIONS-1:0]          s_req_ready,
  input  logic [N_REGIONS*REQ_BITS-1:0] s_req_data,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic [REQ_BITS-1:0]           m_req_data,
  input  logic                          s_cmpl_valid,
  input  logic [N_REGIONS_BITS-1:0]     s_cmpl_vfid,
  input  logic [N_REGIONS-1:0]          cfg_en,
  input  logic [CW-1:0]                 cfg_max_ost,
  output logic [N_REGIONS*CW-1:0]       ost_cnt,
  output logic                          err_underflow
);

  localparam logic [CW-1:0] OST_MAX = CW'(N_OST);

  sched_state_t              state_q, state_d;
  logic [N_REGIONS_BITS-1:0] win_q, win_d;
  logic [N_REGIONS_BITS-1:0] rr_q, rr_d;
  logic [REQ_BITS-1:0]       data_q, data_d;
  logic                      err_q;
  logic [CW-1:0]             cnt_q [N_REGIONS];
  logic [CW-1:0]             cnt_d [N_REGIONS];

  logic [REQ_BITS-1:0]       req_word [N_REGIONS];
  logic [N_REGIONS-1:0]      eligible;
  logic [N_REGIONS-1:0]      inc, dec, uf_hit, cmpl_hit;
  logic [N_REGIONS-1:0]      pick_gnt;
  logic [N_REGIONS_BITS-1:0] pick_idx;
  logic                      pick_any;
  logic                      accept, send_hs;
  logic [CW-1:0]             lim;

  // Effective credit limit: zero or out-of-range settings fall back to the hard ceiling.
  always_comb begin
    lim = cfg_max_ost;
    if (cfg_max_ost == '0 || cfg_max_ost > OST_MAX) lim = OST_MAX;
  end

  assign send_hs = (state_q == ST_SEND) && m_req_ready;
  assign accept  = (state_q == ST_IDLE) && pick_any;

  // Per-region eligibility and credit bookkeeping; a send and a completion in the
  // same cycle on one region cancel out.
  generate
    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
      assign req_word[gi] = s_req_data[gi*REQ_BITS +: REQ_BITS];
      assign eligible[gi] = s_req_valid[gi] & cfg_en[gi] & (cnt_q[gi] < lim);
      assign inc[gi]      = send_hs && (win_q == N_REGIONS_BITS'(gi));
      assign cmpl_hit[gi] = s_cmpl_valid && (s_cmpl_vfid == N_REGIONS_BITS'(gi));
      assign dec[gi]      = cmpl_hit[gi] && (cnt_q[gi] != '0);
      assign uf_hit[gi]   = cmpl_hit[gi] && (cnt_q[gi] == '0);
      assign cnt_d[gi]    = cnt_q[gi] + CW'(inc[gi]) - CW'(dec[gi]);
      assign ost_cnt[gi*CW +: CW] = cnt_q[gi];
    end
  endgenerate

  rr_prio_pick #(
    .N  (N_REGIONS),
    .IW (N_REGIONS_BITS)
  ) u_pick (
    .req_i (eligible),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Ready only depends on registered state and requester inputs, never on m_req_ready.
  assign s_req_ready   = accept ? pick_gnt : '0;
  assign m_req_valid   = (state_q == ST_SEND);
  assign m_req_data    = data_q;
  assign err_underflow = err_q;

  // Next-state logic: capture the winner in IDLE, release and advance the pointer on send.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_SEND;
          win_d   = pick_idx;
          data_d  = req_word[pick_idx];
        end
      end
      ST_SEND: begin
        if (m_req_ready) begin
          state_d = ST_IDLE;
          rr_d    = (win_q == N_REGIONS_BITS'(N_REGIONS - 1)) ? '0 : win_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, data, pointer, sticky error and credit counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_REGIONS; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      err_q   <= err_q | (|uf_hit);
      for (int i = 0; i < N_REGIONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
